// File: rtl/serial_pattern_tx_if.sv
// Bus bundle for serial_pattern_tx: transfer request, parallel word and
// repeat settings toward the transmitter, and the serial line, status and
// hit count back from it.
interface serial_pattern_tx_if #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4,
  parameter int GAP_W = 3,
  parameter int HIT_W = 8
);
  logic             start;
  logic [WIDTH-1:0] data;
  logic [CNT_W-1:0] repeat_n;
  logic [GAP_W-1:0] gap;
  logic             a;
  logic             a_valid;
  logic             busy;
  logic             done;
  logic [HIT_W-1:0] hits;

  // Requester side: issues transfers and watches the line.
  modport master (
    output start, data, repeat_n, gap,
    input  a, a_valid, busy, done, hits
  );

  // Transmitter side.
  modport slave (
    input  start, data, repeat_n, gap,
    output a, a_valid, busy, done, hits
  );
endinterface

// File: rtl/serial_pattern_tx.sv
// Serializes a parallel word MSB-first onto a one-bit line, optionally
// repeating it with idle gaps between copies, and counts overlapping
// occurrences of PATTERN in the outgoing line so the expected hit count
// of a downstream sequence detector is known on-chip.
// PAT_LEN must be at least 2.
module serial_pattern_tx #(
  parameter int                 WIDTH   = 8,
  parameter int                 CNT_W   = 4,
  parameter int                 GAP_W   = 3,
  parameter int                 PAT_LEN = 4,
  parameter logic [PAT_LEN-1:0] PATTERN = 4'b0110,
  parameter int                 HIT_W   = 8
) (
  input logic                clk,
  input logic                reset,
  serial_pattern_tx_if.slave bus
);

  localparam int BC_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int HC_W = (PAT_LEN > 2) ? $clog2(PAT_LEN) : 1;
  localparam logic [BC_W-1:0] LAST_BIT = BC_W'(WIDTH - 1);
  localparam logic [HC_W-1:0] ARMED    = HC_W'(PAT_LEN - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, GAP} state_t;

  state_t           state;
  logic [WIDTH-1:0] word;
  logic [WIDTH-1:0] shreg;
  logic [WIDTH-1:0] shreg_next;
  logic [BC_W-1:0]  bit_cnt;
  logic [CNT_W-1:0] copies;
  logic [GAP_W-1:0] gap_len;
  logic [GAP_W-1:0] gap_cnt;

  // Only the PAT_LEN-1 most recent line bits are stored; the bit on the
  // line this cycle completes the PAT_LEN-bit window.
  logic [PAT_LEN-2:0] hist;
  logic [HC_W-1:0]    hist_cnt;
  logic [PAT_LEN-1:0] window;

  // Hit counter increment that sticks at all-ones instead of wrapping.
  function automatic logic [HIT_W-1:0] sat_inc(input logic [HIT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  // Next bit to present is the one just below the current MSB.
  always_comb begin
    shreg_next = shreg << 1;
    window     = {hist, bus.a};
  end

  // Transfer sequencer: IDLE -> SHIFT (-> GAP -> SHIFT)* -> IDLE, all outputs registered.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      bus.a       <= 1'b0;
      bus.a_valid <= 1'b0;
      bus.busy    <= 1'b0;
      bus.done    <= 1'b0;
      bit_cnt     <= '0;
      copies      <= '0;
      gap_len     <= '0;
      gap_cnt     <= '0;
    end else begin
      bus.done <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            word        <= bus.data;
            shreg       <= bus.data;
            copies      <= (bus.repeat_n == '0) ? CNT_W'(1) : bus.repeat_n;
            gap_len     <= bus.gap;
            bit_cnt     <= LAST_BIT;
            bus.a       <= bus.data[WIDTH-1];
            bus.a_valid <= 1'b1;
            bus.busy    <= 1'b1;
            state       <= SHIFT;
          end
        end

        SHIFT: begin
          if (bit_cnt != '0) begin
            shreg   <= shreg_next;
            bus.a   <= shreg_next[WIDTH-1];
            bit_cnt <= bit_cnt - 1'b1;
          end else if (copies != CNT_W'(1)) begin
            copies <= copies - 1'b1;
            if (gap_len != '0) begin
              gap_cnt     <= gap_len;
              bus.a       <= 1'b0;
              bus.a_valid <= 1'b0;
              state       <= GAP;
            end else begin
              // No gap: next copy starts right behind the last bit.
              shreg   <= word;
              bus.a   <= word[WIDTH-1];
              bit_cnt <= LAST_BIT;
            end
          end else begin
            bus.a       <= 1'b0;
            bus.a_valid <= 1'b0;
            bus.busy    <= 1'b0;
            bus.done    <= 1'b1;
            state       <= IDLE;
          end
        end

        GAP: begin
          if (gap_cnt == GAP_W'(1)) begin
            shreg       <= word;
            bus.a       <= word[WIDTH-1];
            bus.a_valid <= 1'b1;
            bit_cnt     <= LAST_BIT;
            state       <= SHIFT;
          end else begin
            gap_cnt <= gap_cnt - 1'b1;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

  // Pattern tracker: shifts the line on every busy cycle (gap zeros included)
  // and counts windows equal to PATTERN once PAT_LEN bits have been seen.
  always_ff @(posedge clk) begin
    if (reset) begin
      hist     <= '0;
      hist_cnt <= '0;
      bus.hits <= '0;
    end else if (state == IDLE) begin
      if (bus.start) begin
        hist     <= '0;
        hist_cnt <= '0;
        bus.hits <= '0;
      end
    end else begin
      hist <= window[PAT_LEN-2:0];
      if (hist_cnt != ARMED) begin
        hist_cnt <= hist_cnt + 1'b1;
      end
      if (window == PATTERN && hist_cnt == ARMED) begin
        bus.hits <= sat_inc(bus.hits);
      end
    end
  end

endmodule

// File: tb/tb_serial_pattern_tx.sv
// Self-checking bench for serial_pattern_tx. The expected line is built as a
// flat list of (bit, valid) per busy cycle from the word, copy count and gap,
// and the expected hit count is a sliding-window scan over that list.
// HIT_W is reduced to 3 so saturation is reachable.
module tb_serial_pattern_tx;

  localparam int         HW   = 3;
  localparam int         HMAX = (1 << HW) - 1;
  localparam logic [3:0] PAT  = 4'b0110;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   total = 0;
  int   bad = 0;
  bit   q_bits[$];
  bit   q_vals[$];

  serial_pattern_tx_if #(.WIDTH(8), .CNT_W(4), .GAP_W(3), .HIT_W(HW)) bus ();

  serial_pattern_tx #(
    .WIDTH(8), .CNT_W(4), .GAP_W(3), .PAT_LEN(4), .PATTERN(PAT), .HIT_W(HW)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout want completion");
    $fatal(1);
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Reference: line contents per busy cycle and the resulting hit count.
  task automatic build_model(input logic [7:0] d, input int rep, input int g, output int h);
    int n;
    int cnt;
    logic [3:0] w;
    n = (rep == 0) ? 1 : rep;
    q_bits.delete();
    q_vals.delete();
    for (int c = 0; c < n; c++) begin
      for (int b = 7; b >= 0; b--) begin
        q_bits.push_back(d[b]);
        q_vals.push_back(1'b1);
      end
      if (c < n - 1)
        for (int k = 0; k < g; k++) begin
          q_bits.push_back(1'b0);
          q_vals.push_back(1'b0);
        end
    end
    cnt = 0;
    for (int i = 3; i < q_bits.size(); i++) begin
      w = {q_bits[i-3], q_bits[i-2], q_bits[i-1], q_bits[i]};
      if (w == PAT) cnt++;
    end
    h = (cnt > HMAX) ? HMAX : cnt;
  endtask

  task automatic test_reset;
    logic [3:0] obs;
    bus.start = 1'b0;
    bus.data = '0;
    bus.repeat_n = '0;
    bus.gap = '0;
    reset = 1'b1;
    tick;
    tick;
    reset = 1'b0;
    obs = {bus.a, bus.a_valid, bus.busy, bus.done};
    total++;
    if (obs !== 4'b0000) begin
      bad++;
      $display("FAIL reset_outputs: a/valid/busy/done=%b want 0000", obs);
    end
    total++;
    if (bus.hits !== '0) begin
      bad++;
      $display("FAIL reset_hits: got %0d want 0", bus.hits);
    end
    tick;
  endtask

  // Full transfer from IDLE: every busy cycle, the done cycle, and the hold after.
  task automatic test_transfer(input string name, input logic [7:0] d, input int rep, input int g);
    int h;
    logic [3:0] obs;
    logic [3:0] expv;
    logic [HW-1:0] held;
    build_model(d, rep, g, h);
    bus.data = d;
    bus.repeat_n = rep[3:0];
    bus.gap = g[2:0];
    bus.start = 1'b1;
    tick;
    bus.start = 1'b0;
    bus.data = 8'($urandom);
    bus.repeat_n = 4'($urandom);
    bus.gap = 3'($urandom);
    for (int i = 0; i < q_bits.size(); i++) begin
      obs = {bus.a, bus.a_valid, bus.busy, bus.done};
      expv = {q_bits[i], q_vals[i], 1'b1, 1'b0};
      total++;
      if (obs !== expv) begin
        bad++;
        $display("FAIL %s cycle %0d: a/valid/busy/done=%b want %b", name, i, obs, expv);
      end
      tick;
    end
    obs = {bus.a, bus.a_valid, bus.busy, bus.done};
    total++;
    if (obs !== 4'b0001) begin
      bad++;
      $display("FAIL %s done_cycle: a/valid/busy/done=%b want 0001", name, obs);
    end
    total++;
    if (bus.hits !== HW'(h)) begin
      bad++;
      $display("FAIL %s hits: got %0d want %0d", name, bus.hits, h);
    end
    held = bus.hits;
    tick;
    total++;
    if ({bus.busy, bus.done, bus.hits} !== {2'b00, HW'(h)}) begin
      bad++;
      $display("FAIL %s after_done: busy=%b done=%b hits=%0d want 0 0 %0d (was %0d)",
               name, bus.busy, bus.done, bus.hits, h, held);
    end
  endtask

  task automatic test_start_ignored;
    int h;
    logic [3:0] obs;
    logic [3:0] expv;
    build_model(8'h66, 1, 0, h);
    bus.data = 8'h66;
    bus.repeat_n = 4'd1;
    bus.gap = 3'd0;
    bus.start = 1'b1;
    tick;
    bus.start = 1'b0;
    for (int i = 0; i < q_bits.size(); i++) begin
      if (i == 2) begin
        bus.start = 1'b1;
        bus.data = 8'h99;
        bus.repeat_n = 4'd3;
        bus.gap = 3'd5;
      end else begin
        bus.start = 1'b0;
      end
      obs = {bus.a, bus.a_valid, bus.busy, bus.done};
      expv = {q_bits[i], q_vals[i], 1'b1, 1'b0};
      total++;
      if (obs !== expv) begin
        bad++;
        $display("FAIL ignore_start cycle %0d: a/valid/busy/done=%b want %b", i, obs, expv);
      end
      tick;
    end
    total++;
    if ({bus.done, bus.busy, bus.hits} !== {2'b10, HW'(h)}) begin
      bad++;
      $display("FAIL ignore_start end: done=%b busy=%b hits=%0d want 1 0 %0d",
               bus.done, bus.busy, bus.hits, h);
    end
    tick;
  endtask

  task automatic test_start_in_done;
    int h;
    logic [3:0] obs;
    logic [3:0] expv;
    build_model(8'h66, 1, 0, h);
    bus.data = 8'h66;
    bus.repeat_n = 4'd1;
    bus.gap = 3'd0;
    bus.start = 1'b1;
    tick;
    bus.start = 1'b0;
    repeat (8) tick;
    total++;
    if ({bus.done, bus.hits} !== {1'b1, HW'(h)}) begin
      bad++;
      $display("FAIL done_start first_end: done=%b hits=%0d want 1 %0d", bus.done, bus.hits, h);
    end
    build_model(8'hB6, 1, 0, h);
    bus.data = 8'hB6;
    bus.start = 1'b1;
    tick;
    bus.start = 1'b0;
    total++;
    if ({bus.a, bus.a_valid, bus.busy, bus.hits} !== {3'b111, HW'(0)}) begin
      bad++;
      $display("FAIL done_start launch: a/valid/busy=%b%b%b hits=%0d want 111 0",
               bus.a, bus.a_valid, bus.busy, bus.hits);
    end
    for (int i = 0; i < q_bits.size(); i++) begin
      obs = {bus.a, bus.a_valid, bus.busy, bus.done};
      expv = {q_bits[i], q_vals[i], 1'b1, 1'b0};
      total++;
      if (obs !== expv) begin
        bad++;
        $display("FAIL done_start cycle %0d: a/valid/busy/done=%b want %b", i, obs, expv);
      end
      tick;
    end
    total++;
    if ({bus.done, bus.hits} !== {1'b1, HW'(h)}) begin
      bad++;
      $display("FAIL done_start second_end: done=%b hits=%0d want 1 %0d", bus.done, bus.hits, h);
    end
    tick;
  endtask

  task automatic test_reset_mid;
    int h;
    logic [3:0] obs;
    build_model(8'h66, 1, 0, h);
    bus.data = 8'h66;
    bus.repeat_n = 4'd1;
    bus.gap = 3'd0;
    bus.start = 1'b1;
    tick;
    bus.start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      obs = {bus.a, bus.a_valid, bus.busy, bus.done};
      total++;
      if (obs !== {q_bits[i], 3'b110}) begin
        bad++;
        $display("FAIL reset_mid cycle %0d: a/valid/busy/done=%b want %b", i, obs, {q_bits[i], 3'b110});
      end
      if (i < 4) tick;
    end
    reset = 1'b1;
    tick;
    reset = 1'b0;
    obs = {bus.a, bus.a_valid, bus.busy, bus.done};
    total++;
    if ({obs, bus.hits} !== {4'b0000, HW'(0)}) begin
      bad++;
      $display("FAIL reset_mid abort: a/valid/busy/done=%b hits=%0d want 0000 0", obs, bus.hits);
    end
    for (int i = 0; i < 6; i++) begin
      tick;
      total++;
      if ({bus.done, bus.busy} !== 2'b00) begin
        bad++;
        $display("FAIL reset_mid quiet %0d: done=%b busy=%b want 0 0", i, bus.done, bus.busy);
      end
    end
    test_transfer("after_reset", 8'h66, 1, 0);
  endtask

  task automatic test_random;
    for (int k = 0; k < 25; k++) begin
      test_transfer("random", 8'($urandom), $urandom_range(0, 5), $urandom_range(0, 7));
    end
  endtask

  initial begin
    test_reset;
    test_transfer("single", 8'b01100110, 1, 0);
    test_transfer("overlap", 8'b01101100, 1, 0);
    test_transfer("repeat_gap", 8'h66, 3, 2);
    test_transfer("back_to_back", 8'b00000011, 2, 0);
    test_transfer("repeat_zero", 8'h66, 0, 0);
    test_transfer("saturate", 8'h66, 5, 0);
    test_start_ignored;
    test_start_in_done;
    test_reset_mid;
    test_random;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
